// File: rtl/zd_pkg.sv
// Shared constants for the HPS instruction receiver: opcodes, instruction field
// positions, error codes and the receiver FSM state encoding.
package zd_pkg;

  localparam logic [2:0] OP_NOP      = 3'd0;
  localparam logic [2:0] OP_WR_PIX   = 3'd1;
  localparam logic [2:0] OP_ZIN_NN   = 3'd2;
  localparam logic [2:0] OP_ZIN_REP  = 3'd3;
  localparam logic [2:0] OP_ZOUT_DEC = 3'd4;
  localparam logic [2:0] OP_ZOUT_AVG = 3'd5;
  localparam logic [2:0] OP_RST_VIEW = 3'd6;
  localparam logic [2:0] OP_ILLEGAL  = 3'd7;

  localparam int OP_LSB     = 0;
  localparam int OP_MSB     = 2;
  localparam int FACTOR_LSB = 3;
  localparam int FACTOR_MSB = 4;
  localparam int ADDR_LSB   = 5;
  localparam int DATA_LSB   = 22;
  localparam int DATA_MSB   = 29;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_BAD_OP   = 2'd1;
  localparam logic [1:0] ERR_BAD_OPND = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

  localparam logic [1:0] FACTOR_BAD = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } zd_state_e;

endpackage

// File: rtl/zd_instr_decode.sv
// Combinational split of the 32-bit instruction word into command fields plus
// the legality check that picks the error code for a rejected instruction.
module zd_instr_decode
  import zd_pkg::*;
#(
  parameter int IMG_W  = 320,
  parameter int IMG_H  = 240,
  parameter int ADDR_W = 17
) (
  input  logic [31:0]       instr_i,
  output logic [2:0]        op_o,
  output logic [1:0]        factor_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [7:0]        data_o,
  output logic              ok_o,
  output logic [1:0]        err_code_o
);

  localparam logic [31:0] PIX_COUNT = 32'(IMG_W * IMG_H);

  logic [1:0] w_unused_bits;

  assign op_o          = instr_i[OP_MSB:OP_LSB];
  assign factor_o      = instr_i[FACTOR_MSB:FACTOR_LSB];
  assign addr_o        = instr_i[ADDR_LSB +: ADDR_W];
  assign data_o        = instr_i[DATA_MSB:DATA_LSB];
  assign w_unused_bits = instr_i[31:30];

  always_comb begin
    ok_o       = 1'b1;
    err_code_o = ERR_NONE;
    case (op_o)
      OP_ILLEGAL: begin
        ok_o       = 1'b0;
        err_code_o = ERR_BAD_OP;
      end
      OP_ZIN_NN, OP_ZIN_REP, OP_ZOUT_DEC, OP_ZOUT_AVG: begin
        if (factor_o == FACTOR_BAD) begin
          ok_o       = 1'b0;
          err_code_o = ERR_BAD_OPND;
        end
      end
      OP_WR_PIX: begin
        if (32'(addr_o) >= PIX_COUNT) begin
          ok_o       = 1'b0;
          err_code_o = ERR_BAD_OPND;
        end
      end
      OP_NOP, OP_RST_VIEW: ;
      default: ;
    endcase
  end

endmodule

// File: rtl/zd_instr_receiver.sv
// HPS instruction PIO responder: enable edge detect, command issue to the zoom
// engine and the 4-phase done/err handshake. Define ZD_RX_TIMEOUT_EN for the watchdog.
module zd_instr_receiver
  import zd_pkg::*;
#(
  parameter int          IMG_W          = 320,
  parameter int          IMG_H          = 240,
  parameter int          ADDR_W         = 17,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [31:0]       instr_i,
  input  logic              instr_en_i,
  output logic              cmd_valid_o,
  input  logic              cmd_ready_i,
  output logic [2:0]        cmd_op_o,
  output logic [1:0]        cmd_factor_o,
  output logic [ADDR_W-1:0] cmd_addr_o,
  output logic [7:0]        cmd_data_o,
  input  logic              eng_done_i,
  output logic              stat_busy_o,
  output logic              stat_done_o,
  output logic              stat_err_o,
  output logic [1:0]        stat_code_o
);

  zd_state_e         r_state;
  logic              r_en_q;
  logic              r_cmd_valid;
  logic [2:0]        r_cmd_op;
  logic [1:0]        r_cmd_factor;
  logic [ADDR_W-1:0] r_cmd_addr;
  logic [7:0]        r_cmd_data;
  logic              r_stat_busy;
  logic              r_stat_done;
  logic              r_stat_err;
  logic [1:0]        r_stat_code;

  logic              w_rise;
  logic              w_wd_expire;
  logic [2:0]        w_op;
  logic [1:0]        w_factor;
  logic [ADDR_W-1:0] w_addr;
  logic [7:0]        w_data;
  logic              w_ok;
  logic [1:0]        w_err_code;

  zd_instr_decode #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .ADDR_W (ADDR_W)
  ) u_decode (
    .instr_i    (instr_i),
    .op_o       (w_op),
    .factor_o   (w_factor),
    .addr_o     (w_addr),
    .data_o     (w_data),
    .ok_o       (w_ok),
    .err_code_o (w_err_code)
  );

  assign w_rise = instr_en_i & ~r_en_q;

`ifdef ZD_RX_TIMEOUT_EN
  logic [31:0] r_wd_cnt;

  assign w_wd_expire = (r_wd_cnt == 32'(TIMEOUT_CYCLES - 1));

  // Held at zero in IDLE so the count starts fresh on every entry to ISSUE.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_wd_cnt <= '0;
    end else if (r_state == ST_IDLE) begin
      r_wd_cnt <= '0;
    end else if (r_state == ST_ISSUE || r_state == ST_WAIT) begin
      r_wd_cnt <= r_wd_cnt + 32'd1;
    end
  end
`else
  logic w_unused_timeout;

  assign w_wd_expire      = 1'b0;
  assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_state      <= ST_IDLE;
      r_en_q       <= 1'b0;
      r_cmd_valid  <= 1'b0;
      r_cmd_op     <= '0;
      r_cmd_factor <= '0;
      r_cmd_addr   <= '0;
      r_cmd_data   <= '0;
      r_stat_busy  <= 1'b0;
      r_stat_done  <= 1'b0;
      r_stat_err   <= 1'b0;
      r_stat_code  <= ERR_NONE;
    end else begin
      r_en_q <= instr_en_i;
      case (r_state)
        ST_IDLE: begin
          if (w_rise) begin
            r_cmd_op     <= w_op;
            r_cmd_factor <= w_factor;
            r_cmd_addr   <= w_addr;
            r_cmd_data   <= w_data;
            if (!w_ok) begin
              r_state     <= ST_ERR;
              r_stat_err  <= 1'b1;
              r_stat_code <= w_err_code;
            end else if (w_op == OP_NOP) begin
              r_state     <= ST_DONE;
              r_stat_done <= 1'b1;
            end else begin
              r_state     <= ST_ISSUE;
              r_cmd_valid <= 1'b1;
              r_stat_busy <= 1'b1;
            end
          end
        end
        ST_ISSUE, ST_WAIT: begin
          if (w_wd_expire) begin
            r_state     <= ST_ERR;
            r_cmd_valid <= 1'b0;
            r_stat_busy <= 1'b0;
            r_stat_err  <= 1'b1;
            r_stat_code <= ERR_TIMEOUT;
          end else if (r_state == ST_ISSUE && cmd_ready_i) begin
            r_state     <= ST_WAIT;
            r_cmd_valid <= 1'b0;
          end else if (r_state == ST_WAIT && eng_done_i) begin
            r_state     <= ST_DONE;
            r_stat_busy <= 1'b0;
            r_stat_done <= 1'b1;
          end
        end
        ST_DONE: begin
          if (!instr_en_i) begin
            r_state     <= ST_IDLE;
            r_stat_done <= 1'b0;
          end
        end
        ST_ERR: begin
          if (!instr_en_i) begin
            r_state     <= ST_IDLE;
            r_stat_err  <= 1'b0;
            r_stat_code <= ERR_NONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_valid_o  = r_cmd_valid;
  assign cmd_op_o     = r_cmd_op;
  assign cmd_factor_o = r_cmd_factor;
  assign cmd_addr_o   = r_cmd_addr;
  assign cmd_data_o   = r_cmd_data;
  assign stat_busy_o  = r_stat_busy;
  assign stat_done_o  = r_stat_done;
  assign stat_err_o   = r_stat_err;
  assign stat_code_o  = r_stat_code;

endmodule
